// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// ALU operation codes and datapath mux selects.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_B     = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_BRIMM = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic isSupportedOp(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: opcode/flags/memory-ready in, enables and selects out.
interface multicycle_ctrl_if;

    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcen;
    logic       illegal_op;
    logic [3:0] state_o;

    modport master (
        input  op, zero, mem_ready,
        output iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, aluop, pcsrc, pcen, illegal_op, state_o
    );

    modport slave (
        output op, zero, mem_ready,
        input  iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, aluop, pcsrc, pcen, illegal_op, state_o
    );

endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// for R-type, LW, SW, BEQ, ADDI and J, stalling on the memory-ready handshake.
module multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    multicycle_ctrl_if.master bus
);

    state_e     r_state;
    state_e     w_next;
    logic       w_memReady;
    logic       w_pcWrite;
    logic       w_branch;
    logic       w_iord;
    logic       w_memwrite;
    logic       w_irwrite;
    logic       w_regdst;
    logic       w_memtoreg;
    logic       w_regwrite;
    logic       w_alusrca;
    logic [1:0] w_alusrcb;
    logic [1:0] w_aluop;
    logic [1:0] w_pcsrc;
    logic       w_illegal;

    assign w_memReady = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:   w_next = w_memReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.op)
                    OP_RTYPE:     w_next = S_EXECUTE;
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JUMP;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (bus.op == OP_LW) begin
                    w_next = S_MEMRD;
                end else if (bus.op == OP_SW) begin
                    w_next = S_MEMWR;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_MEMRD:   w_next = w_memReady ? S_MEMWB : S_MEMRD;
            S_MEMWB:   w_next = S_FETCH;
            S_MEMWR:   w_next = w_memReady ? S_FETCH : S_MEMWR;
            S_EXECUTE: w_next = S_ALUWB;
            S_ALUWB:   w_next = S_FETCH;
            S_BRANCH:  w_next = S_FETCH;
            S_ADDIEX:  w_next = S_ADDIWB;
            S_ADDIWB:  w_next = S_FETCH;
            S_JUMP:    w_next = S_FETCH;
            default:   w_next = S_FETCH;
        endcase
    end

    // Outputs are forced low for as long as reset is held, even though the
    // state register already reads FETCH, so no access starts under reset.
    always_comb begin
        w_iord     = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_regdst   = 1'b0;
        w_memtoreg = 1'b0;
        w_regwrite = 1'b0;
        w_alusrca  = 1'b0;
        w_alusrcb  = ALUSRCB_B;
        w_aluop    = ALUOP_ADD;
        w_pcsrc    = PCSRC_ALU;
        w_pcWrite  = 1'b0;
        w_branch   = 1'b0;
        w_illegal  = 1'b0;
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    w_alusrcb = ALUSRCB_FOUR;
                    w_irwrite = w_memReady;
                    w_pcWrite = w_memReady;
                end
                S_DECODE: begin
                    w_alusrcb = ALUSRCB_BRIMM;
                    w_illegal = !isSupportedOp(bus.op);
                end
                S_MEMADR, S_ADDIEX: begin
                    w_alusrca = 1'b1;
                    w_alusrcb = ALUSRCB_IMM;
                end
                S_MEMRD: w_iord = 1'b1;
                S_MEMWB: begin
                    w_memtoreg = 1'b1;
                    w_regwrite = 1'b1;
                end
                S_MEMWR: begin
                    w_iord     = 1'b1;
                    w_memwrite = 1'b1;
                end
                S_EXECUTE: begin
                    w_alusrca = 1'b1;
                    w_aluop   = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    w_regdst   = 1'b1;
                    w_regwrite = 1'b1;
                end
                S_BRANCH: begin
                    w_alusrca = 1'b1;
                    w_aluop   = ALUOP_SUB;
                    w_pcsrc   = PCSRC_ALUOUT;
                    w_branch  = 1'b1;
                end
                S_ADDIWB: w_regwrite = 1'b1;
                S_JUMP: begin
                    w_pcsrc   = PCSRC_JUMP;
                    w_pcWrite = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.iord       = w_iord;
    assign bus.memwrite   = w_memwrite;
    assign bus.irwrite    = w_irwrite;
    assign bus.regdst     = w_regdst;
    assign bus.memtoreg   = w_memtoreg;
    assign bus.regwrite   = w_regwrite;
    assign bus.alusrca    = w_alusrca;
    assign bus.alusrcb    = w_alusrcb;
    assign bus.aluop      = w_aluop;
    assign bus.pcsrc      = w_pcsrc;
    assign bus.pcen       = w_pcWrite | (w_branch & bus.zero);
    assign bus.illegal_op = w_illegal;
    assign bus.state_o    = r_state;

endmodule
